transpose_stream: RTL and testbench

//  Streaming ROWS x COLS matrix transpose with internal buffering; sequential successor to the flat wire-remap transpose.

---
 rtl/transpose_stream.sv | 189 ++++++++++++++++++
 tb/tb_transpose_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_stream.sv
// transpose_stream: streaming ROWS x COLS matrix buffer emitting column-major (transpose) or row-major (pass).
// Define TRANSPOSE_PINGPONG_EN for two banks (double buffering); otherwise a single bank is used.
module transpose_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  mode_trans,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = $clog2(N);
  localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int C_W   = (COLS > 1) ? $clog2(COLS) : 1;
`ifdef TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_state_e;

  bank_state_e bankState_q [NB];
  bank_state_e bankState_d [NB];
  logic        bankMode_q  [NB];
  logic        bankMode_d  [NB];

  logic [DATA_WIDTH-1:0] mem_q [NB][N];

  logic            wrBank_q, wrBank_d;
  logic            rdBank_q, rdBank_d;
  logic            outBank_q, outBank_d;
  logic [R_W-1:0]  wrR_q, wrR_d, rdR_q, rdR_d;
  logic [C_W-1:0]  wrC_q, wrC_d, rdC_q, rdC_d;
  logic            rdBusy_q, rdBusy_d;

  logic                  outValid_q, outValid_d;
  logic                  outLast_q, outLast_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;

  logic             wrFire, wrLast, outFire, canLoad, rdLast, rdMode;
  logic [CNT_W-1:0] wrAddr, rdAddr;

  assign in_ready  = (bankState_q[wrBank_q] == EMPTY) || (bankState_q[wrBank_q] == FILL);
  assign out_valid = outValid_q;
  assign out_last  = outLast_q;
  assign out_data  = outData_q;

  assign wrFire  = in_valid && in_ready;
  assign wrLast  = (wrR_q == R_W'(ROWS - 1)) && (wrC_q == C_W'(COLS - 1));
  assign rdLast  = (rdR_q == R_W'(ROWS - 1)) && (rdC_q == C_W'(COLS - 1));
  assign outFire = outValid_q && out_ready;
  assign rdMode  = bankMode_q[rdBank_q];
  assign wrAddr  = CNT_W'(int'(wrR_q) * COLS + int'(wrC_q));
  assign rdAddr  = CNT_W'(int'(rdR_q) * COLS + int'(rdC_q));

  // rdBusy marks a DRAIN bank that still has elements not yet moved into the output register;
  // the bank itself stays DRAIN until its last element is actually handed off downstream.
  assign canLoad = (!outValid_q || out_ready) &&
                   ((bankState_q[rdBank_q] == FULL) ||
                    ((bankState_q[rdBank_q] == DRAIN) && rdBusy_q));

  always_comb begin
    bankState_d = bankState_q;
    bankMode_d  = bankMode_q;
    wrBank_d    = wrBank_q;
    rdBank_d    = rdBank_q;
    outBank_d   = outBank_q;
    wrR_d       = wrR_q;
    wrC_d       = wrC_q;
    rdR_d       = rdR_q;
    rdC_d       = rdC_q;
    rdBusy_d    = rdBusy_q;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;
    outData_d   = outData_q;

    if (wrFire) begin
      if (bankState_q[wrBank_q] == EMPTY) begin
        bankMode_d[wrBank_q]  = mode_trans;
        bankState_d[wrBank_q] = FILL;
      end
      if (wrLast) begin
        bankState_d[wrBank_q] = FULL;
        wrR_d = '0;
        wrC_d = '0;
`ifdef TRANSPOSE_PINGPONG_EN
        wrBank_d = ~wrBank_q;
`endif
      end else if (wrC_q == C_W'(COLS - 1)) begin
        wrC_d = '0;
        wrR_d = wrR_q + R_W'(1);
      end else begin
        wrC_d = wrC_q + C_W'(1);
      end
    end

    if (outFire && outLast_q) begin
      bankState_d[outBank_q] = EMPTY;
    end

    if (canLoad) begin
      outValid_d = 1'b1;
      outData_d  = mem_q[rdBank_q][rdAddr];
      outLast_d  = rdLast;
      outBank_d  = rdBank_q;
      if (bankState_q[rdBank_q] == FULL) begin
        bankState_d[rdBank_q] = DRAIN;
        rdBusy_d = 1'b1;
      end
      if (rdLast) begin
        rdBusy_d = 1'b0;
        rdR_d    = '0;
        rdC_d    = '0;
`ifdef TRANSPOSE_PINGPONG_EN
        rdBank_d = ~rdBank_q;
`endif
      end else if (rdMode) begin
        if (rdR_q == R_W'(ROWS - 1)) begin
          rdR_d = '0;
          rdC_d = rdC_q + C_W'(1);
        end else begin
          rdR_d = rdR_q + R_W'(1);
        end
      end else begin
        if (rdC_q == C_W'(COLS - 1)) begin
          rdC_d = '0;
          rdR_d = rdR_q + R_W'(1);
        end else begin
          rdC_d = rdC_q + C_W'(1);
        end
      end
    end else if (outFire) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        bankState_q[b] <= EMPTY;
        bankMode_q[b]  <= 1'b0;
      end
      wrBank_q   <= 1'b0;
      rdBank_q   <= 1'b0;
      outBank_q  <= 1'b0;
      wrR_q      <= '0;
      wrC_q      <= '0;
      rdR_q      <= '0;
      rdC_q      <= '0;
      rdBusy_q   <= 1'b0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outData_q  <= '0;
    end else begin
      bankState_q <= bankState_d;
      bankMode_q  <= bankMode_d;
      wrBank_q    <= wrBank_d;
      rdBank_q    <= rdBank_d;
      outBank_q   <= outBank_d;
      wrR_q       <= wrR_d;
      wrC_q       <= wrC_d;
      rdR_q       <= rdR_d;
      rdC_q       <= rdC_d;
      rdBusy_q    <= rdBusy_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
      outData_q   <= outData_d;
    end
  end

  // Element storage needs no reset: bank state alone decides what is valid.
  always_ff @(posedge clk_p) begin
    if (wrFire) begin
      mem_q[wrBank_q][wrAddr] <= in_data;
    end
  end

endmodule

// File: tb/tb_transpose_stream.sv
// tb_transpose_stream: directed checks of transpose_stream with ROWS=2, COLS=3, DATA_WIDTH=8.
// Expectations follow TRANSPOSE_PINGPONG_EN when it is defined for the build.
module tb_transpose_stream;

  logic       clk_p = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       mode_trans = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;

  int nVec = 0;
  int nErr = 0;
  int cyc = 0;
  logic trackStall = 1'b0;

  logic [7:0] outData [$];
  logic       outLast [$];
  int         outCycQ [$];
  int         inCycQ  [$];
  int         stallQ  [$];
  int         inData  [$];
  logic       inMode  [$];

  always #5 clk_p = ~clk_p;

  transpose_stream #(.DATA_WIDTH(8), .ROWS(2), .COLS(3)) dut (
    .clk_p(clk_p), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode_trans(mode_trans),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always @(posedge clk_p) cyc <= cyc + 1;

  // Handshakes are recorded mid-cycle; they complete on the following rising edge.
  always @(negedge clk_p) begin
    if (rst_n) begin
      if (in_valid && in_ready) inCycQ.push_back(cyc);
      if (out_valid && out_ready) begin
        outData.push_back(out_data);
        outLast.push_back(out_last);
        outCycQ.push_back(cyc);
      end
      if (trackStall && !in_ready) stallQ.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clearMon();
    outData.delete(); outLast.delete(); outCycQ.delete();
    inCycQ.delete(); stallQ.delete(); inData.delete(); inMode.delete();
  endtask

  task automatic syncCycle();
    @(posedge clk_p); #1;
  endtask

  task automatic loadMatrix(input int base, input logic m0, input int flipBeat, input logic m1);
    for (int i = 0; i < 6; i++) begin
      inData.push_back(base + i);
      inMode.push_back((i >= flipBeat) ? m1 : m0);
    end
  endtask

  task automatic sendQueued(input int budget);
    int waited;
    for (int i = 0; i < inData.size(); i++) begin
      in_valid = 1'b1;
      in_data = 8'(inData[i]);
      mode_trans = inMode[i];
      waited = 0;
      forever begin
        @(negedge clk_p);
        if (in_ready) break;
        waited++;
        if (waited > budget) begin
          nVec++; nErr++;
          $display("[TB] FAIL send_timeout: beat %0d not accepted, waited %0d cycles, required <= %0d", i, waited, budget);
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk_p); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitOutputs(input int n, input int budget);
    int w = 0;
    while (outData.size() < n && w < budget) begin
      @(negedge clk_p);
      w++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nVec++; if (out_valid !== 1'b0) begin nErr++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    nVec++; if (out_data !== 8'd0) begin nErr++; $display("[TB] FAIL reset_out_data: got %0d want 0", out_data); end
    nVec++; if (out_last !== 1'b0) begin nErr++; $display("[TB] FAIL reset_out_last: got %b want 0", out_last); end
    nVec++; if (in_ready !== 1'b1) begin nErr++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk_p);
    rst_n = 1'b1;
    syncCycle();
  endtask

  task automatic test_transpose();
    int exp [6] = '{1, 4, 2, 5, 3, 6};
    int lat;
    logic [7:0] got;
    clearMon();
    out_ready = 1'b1;
    loadMatrix(1, 1'b1, 99, 1'b1);
    sendQueued(50);
    waitOutputs(6, 50);
    nVec++; if (outData.size() != 6) begin nErr++; $display("[TB] FAIL t1_count: got %0d want 6", outData.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < outData.size()) ? outData[i] : 8'hxx;
      nVec++; if (got !== 8'(exp[i])) begin nErr++; $display("[TB] FAIL t1_data[%0d]: got %0d want %0d", i, got, exp[i]); end
      nVec++; if (i < outLast.size() && outLast[i] !== (i == 5)) begin nErr++; $display("[TB] FAIL t1_last[%0d]: got %b want %b", i, outLast[i], (i == 5)); end
    end
    lat = (outCycQ.size() > 0 && inCycQ.size() == 6) ? outCycQ[0] - inCycQ[5] : -1;
    nVec++; if (lat != 2) begin nErr++; $display("[TB] FAIL t1_latency: got %0d cycles want 2", lat); end
    repeat (2) @(negedge clk_p);
    nVec++; if (out_valid !== 1'b0) begin nErr++; $display("[TB] FAIL t1_idle_valid: got %b want 0", out_valid); end
    syncCycle();
  endtask

  task automatic test_pass_mode_flip();
    logic [7:0] got;
    clearMon();
    out_ready = 1'b1;
    loadMatrix(1, 1'b0, 2, 1'b1);
    sendQueued(50);
    waitOutputs(6, 50);
    for (int i = 0; i < 6; i++) begin
      got = (i < outData.size()) ? outData[i] : 8'hxx;
      nVec++; if (got !== 8'(i + 1)) begin nErr++; $display("[TB] FAIL t2_data[%0d]: got %0d want %0d", i, got, i + 1); end
    end
    nVec++; if (outLast.size() != 6 || outLast[5] !== 1'b1 || outLast[4] !== 1'b0) begin
      nErr++; $display("[TB] FAIL t2_last: got size %0d, last flag of final %b, want 6 and 1", outLast.size(), (outLast.size() == 6) ? outLast[5] : 1'bx);
    end
    syncCycle();
  endtask

  task automatic test_random_ready();
    int exp [6] = '{1, 4, 2, 5, 3, 6};
    logic [7:0] got, pd;
    logic pv, pl;
    int it;
    clearMon();
    loadMatrix(1, 1'b1, 99, 1'b1);
    pv = 1'b0; pl = 1'b0; pd = 8'd0; it = 0;
    fork
      sendQueued(100);
      begin
        while (outData.size() < 6 && it < 300) begin
          @(posedge clk_p); #1;
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk_p);
          if (pv) begin
            nVec++;
            if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
              nErr++;
              $display("[TB] FAIL t3_stable: got v=%b d=%0d l=%b want v=1 d=%0d l=%b", out_valid, out_data, out_last, pd, pl);
            end
          end
          pv = out_valid && !out_ready;
          pd = out_data;
          pl = out_last;
          it++;
        end
        out_ready = 1'b1;
      end
    join
    nVec++; if (outData.size() != 6) begin nErr++; $display("[TB] FAIL t3_count: got %0d want 6", outData.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < outData.size()) ? outData[i] : 8'hxx;
      nVec++; if (got !== 8'(exp[i])) begin nErr++; $display("[TB] FAIL t3_data[%0d]: got %0d want %0d", i, got, exp[i]); end
    end
    syncCycle();
  endtask

  task automatic test_back_to_back();
    int exp [12] = '{1, 4, 2, 5, 3, 6, 11, 14, 12, 15, 13, 16};
    logic [7:0] got;
    clearMon();
    out_ready = 1'b1;
    loadMatrix(1, 1'b1, 99, 1'b1);
    loadMatrix(11, 1'b1, 99, 1'b1);
    trackStall = 1'b1;
    sendQueued(100);
    trackStall = 1'b0;
    waitOutputs(12, 100);
    for (int i = 0; i < 12; i++) begin
      got = (i < outData.size()) ? outData[i] : 8'hxx;
      nVec++; if (got !== 8'(exp[i])) begin nErr++; $display("[TB] FAIL b2b_data[%0d]: got %0d want %0d", i, got, exp[i]); end
      nVec++; if (i < outLast.size() && outLast[i] !== (i % 6 == 5)) begin nErr++; $display("[TB] FAIL b2b_last[%0d]: got %b want %b", i, outLast[i], (i % 6 == 5)); end
    end
`ifdef TRANSPOSE_PINGPONG_EN
    nVec++; if (stallQ.size() != 0) begin nErr++; $display("[TB] FAIL b2b_stall: got %0d stall cycles want 0", stallQ.size()); end
    nVec++; if (inCycQ.size() != 12 || inCycQ[11] - inCycQ[0] != 11) begin
      nErr++; $display("[TB] FAIL b2b_in_span: got %0d beats, span %0d want 12 beats span 11", inCycQ.size(), (inCycQ.size() == 12) ? inCycQ[11] - inCycQ[0] : -1);
    end
    nVec++; if (outCycQ.size() != 12 || outCycQ[11] - outCycQ[0] != 11) begin
      nErr++; $display("[TB] FAIL b2b_out_gapless: got %0d outs, span %0d want 12 outs span 11", outCycQ.size(), (outCycQ.size() == 12) ? outCycQ[11] - outCycQ[0] : -1);
    end
`else
    nVec++; if (stallQ.size() < 6) begin nErr++; $display("[TB] FAIL b2b_stall: got %0d stall cycles want >= 6", stallQ.size()); end
`endif
    syncCycle();
  endtask

  task automatic test_reset_mid_drain();
    int exp [6] = '{21, 24, 22, 25, 23, 26};
    logic [7:0] got;
    clearMon();
    out_ready = 1'b1;
    loadMatrix(1, 1'b1, 99, 1'b1);
    sendQueued(50);
    waitOutputs(3, 50);
    nVec++; if (outData.size() < 3) begin nErr++; $display("[TB] FAIL t6_pre_outputs: got %0d want >= 3", outData.size()); end
    @(posedge clk_p); #2;
    rst_n = 1'b0;
    #1;
    nVec++; if (out_valid !== 1'b0) begin nErr++; $display("[TB] FAIL t6_rst_valid: got %b want 0", out_valid); end
    nVec++; if (in_ready !== 1'b1) begin nErr++; $display("[TB] FAIL t6_rst_in_ready: got %b want 1", in_ready); end
    nVec++; if (out_data !== 8'd0 || out_last !== 1'b0) begin nErr++; $display("[TB] FAIL t6_rst_data: got d=%0d l=%b want 0 0", out_data, out_last); end
    @(negedge clk_p);
    rst_n = 1'b1;
    clearMon();
    syncCycle();
    loadMatrix(21, 1'b1, 99, 1'b1);
    sendQueued(50);
    waitOutputs(6, 50);
    nVec++; if (outData.size() != 6) begin nErr++; $display("[TB] FAIL t6_count: got %0d want 6", outData.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < outData.size()) ? outData[i] : 8'hxx;
      nVec++; if (got !== 8'(exp[i])) begin nErr++; $display("[TB] FAIL t6_data[%0d]: got %0d want %0d", i, got, exp[i]); end
    end
    syncCycle();
  endtask

  initial begin
    test_reset();
    test_transpose();
    test_pass_mode_flip();
    test_random_ready();
    test_back_to_back();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
